evm_ballot_ctrl: RTL

Parametrised electronic-voting controller: NUM_CAND candidate buttons, CNT_W-bit saturating tallies, per-voter ballot sessions armed by a polling officer, and a passkey-gated result display with tie detection and lockout after repeated wrong keys. Sits between the button/switch front end and the LED/display back end, replacing the fixed four-party counter.

---
 rtl/evm_ballot_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/evm_ballot_ctrl.sv
// Electronic-voting controller: synchronised candidate buttons, armed voter sessions,
// saturating tallies, and a passkey-gated result display with tie detection and lockout.
module evm_ballot_ctrl #(
  parameter int unsigned         NUM_CAND = 4,
  parameter int unsigned         CNT_W    = 8,
  parameter int unsigned         KEY_W    = 4,
  parameter logic [KEY_W-1:0]    PASSKEY  = KEY_W'(4'b1010),
  parameter int unsigned         MAX_FAIL = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ballot_en,
  input  logic [NUM_CAND-1:0]       button,
  input  logic [KEY_W-1:0]          passkey,
  input  logic                      result_req,
  output logic [NUM_CAND*CNT_W-1:0] count,
  output logic [CNT_W+3:0]          total,
  output logic                      ready,
  output logic                      armed,
  output logic                      vote_ack,
  output logic                      vote_rej,
  output logic [NUM_CAND-1:0]       sat,
  output logic [NUM_CAND-1:0]       led,
  output logic                      tie,
  output logic                      locked
);

  localparam int unsigned TOT_W  = CNT_W + 4;
  localparam int unsigned FAIL_W = 3;
  localparam int unsigned POP_W  = 5;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RESULT, S_LOCKED} state_e;

  state_e                            state_q, state_d;
  logic [NUM_CAND-1:0]               btn_s0_q, btn_s1_q, btn_s2_q;
  logic                              en_s0_q, en_s1_q, en_s2_q;
  logic                              req_q;
  logic [FAIL_W-1:0]                 fail_q, fail_d;
  logic [NUM_CAND-1:0][CNT_W-1:0]    cnt_q, cnt_d;
  logic [TOT_W-1:0]                  total_q, total_d;
  logic [NUM_CAND-1:0]               sat_q, sat_d, led_q, led_d;
  logic                              tie_q, tie_d, ack_q, ack_d, rej_q, rej_d;
  logic                              ready_q, ready_d, armed_q, armed_d, locked_q, locked_d;

  logic [NUM_CAND-1:0] btn_rise;
  logic                arm_rise, req_rise, key_ok;
  logic [POP_W-1:0]    rise_cnt, win_cnt;
  logic [CNT_W-1:0]    max_v;
  logic [NUM_CAND-1:0] win;

  assign btn_rise = btn_s1_q & ~btn_s2_q;
  assign arm_rise = en_s1_q & ~en_s2_q;
  assign req_rise = result_req & ~req_q;
  assign key_ok   = (passkey == PASSKEY);

  // Press count and winner set over current tallies
  always_comb begin
    rise_cnt = '0;
    win_cnt  = '0;
    max_v    = '0;
    win      = '0;
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      rise_cnt = rise_cnt + POP_W'(btn_rise[i]);
      if (cnt_q[i] > max_v) max_v = cnt_q[i];
    end
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      win[i]  = (cnt_q[i] == max_v);
      win_cnt = win_cnt + POP_W'(win[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    rej_d   = 1'b0;
    total_d = '0;
    sat_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (arm_rise) begin
          state_d = S_ARMED;
        end else if (result_req && key_ok) begin
          state_d = S_RESULT;
          fail_d  = '0;
        end else if (req_rise) begin
          fail_d = fail_q + FAIL_W'(1);
          if (fail_q == FAIL_W'(MAX_FAIL - 1)) state_d = S_LOCKED;
        end
      end
      S_ARMED: begin
        if (rise_cnt == POP_W'(1)) begin
          for (int unsigned i = 0; i < NUM_CAND; i++) begin
            if (btn_rise[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
          ack_d   = 1'b1;
          state_d = S_IDLE;
        end else if (rise_cnt > POP_W'(1)) begin
          rej_d = 1'b1;
        end else if (!en_s1_q) begin
          state_d = S_IDLE;
        end
      end
      S_RESULT: begin
        if (!result_req) state_d = S_IDLE;
      end
      S_LOCKED: state_d = S_LOCKED;
      default:  state_d = S_IDLE;
    endcase
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      total_d  = total_d + TOT_W'(cnt_d[i]);
      sat_d[i] = (cnt_d[i] == '1);
    end
    // Display reflects the state held through the previous edge
    led_d    = ((state_q == S_RESULT) && (total_q != '0)) ? win : '0;
    tie_d    = (state_q == S_RESULT) && (total_q != '0) && (win_cnt > POP_W'(1));
    ready_d  = (state_d == S_IDLE);
    armed_d  = (state_d == S_ARMED);
    locked_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      btn_s0_q <= '0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      en_s0_q  <= 1'b0;
      en_s1_q  <= 1'b0;
      en_s2_q  <= 1'b0;
      req_q    <= 1'b0;
      fail_q   <= '0;
      cnt_q    <= '0;
      total_q  <= '0;
      sat_q    <= '0;
      led_q    <= '0;
      tie_q    <= 1'b0;
      ack_q    <= 1'b0;
      rej_q    <= 1'b0;
      ready_q  <= 1'b1;
      armed_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      btn_s0_q <= button;
      btn_s1_q <= btn_s0_q;
      btn_s2_q <= btn_s1_q;
      en_s0_q  <= ballot_en;
      en_s1_q  <= en_s0_q;
      en_s2_q  <= en_s1_q;
      req_q    <= result_req;
      fail_q   <= fail_d;
      cnt_q    <= cnt_d;
      total_q  <= total_d;
      sat_q    <= sat_d;
      led_q    <= led_d;
      tie_q    <= tie_d;
      ack_q    <= ack_d;
      rej_q    <= rej_d;
      ready_q  <= ready_d;
      armed_q  <= armed_d;
      locked_q <= locked_d;
    end
  end

  assign count    = cnt_q;
  assign total    = total_q;
  assign ready    = ready_q;
  assign armed    = armed_q;
  assign vote_ack = ack_q;
  assign vote_rej = rej_q;
  assign sat      = sat_q;
  assign led      = led_q;
  assign tie      = tie_q;
  assign locked   = locked_q;

endmodule
